// File: rtl/psys_route_pkg.sv
// Shared constants and helpers for the data-route fabric stream blocks.
// Default beat/word widths match the DMA-to-systolic-array path.
package psys_route_pkg;

   function automatic int psys_clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int PSYS_BEAT_W = 1536;
   localparam int PSYS_WORD_W = 6144;
   localparam int PSYS_RATIO  = PSYS_WORD_W / PSYS_BEAT_W;

   typedef logic [PSYS_RATIO-1:0] psys_keep_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register with load/drain control.
// It is shared by the upsizer and the matching downsizer.
module axis_out_reg #(
   parameter int DATA_W = 32,
   parameter int KEEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              drain,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEEP_W-1:0] in_keep,
   input  logic              in_last,
   output logic [DATA_W-1:0] tdata,
   output logic [KEEP_W-1:0] tkeep,
   output logic              tlast,
   output logic              tvalid
);

   // Load wins over drain so a handshake plus a new word keeps valid high.
   // Drain drops only valid; the payload stays as it was.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tdata  <= '0;
         tkeep  <= '0;
         tlast  <= 1'b0;
         tvalid <= 1'b0;
      end else if (load) begin
         tdata  <= in_data;
         tkeep  <= in_keep;
         tlast  <= in_last;
         tvalid <= 1'b1;
      end else if (drain) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_upsizer_ws.sv
// Packs RATIO input beats LSB-first into one output word, with early flush
// on tlast, a beat-keep mask and a one-cycle weight-switch pulse.
module axis_upsizer_ws
   import psys_route_pkg::*;
#(
   parameter int IN_W          = PSYS_BEAT_W,
   parameter int RATIO         = 4,
   parameter bit FLUSH_ON_LAST = 1'b1,
   localparam int OUT_W        = IN_W * RATIO,
   localparam int CNT_W        = psys_clog2(RATIO) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   input  logic             weight_switch,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic [RATIO-1:0] m_axis_tkeep,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             weight_switch_out,
   output logic [CNT_W-1:0] beat_cnt_o
);

   logic [RATIO-1:0][IN_W-1:0] asm_data;
   logic [RATIO-1:0][IN_W-1:0] merged_data;
   logic [RATIO-1:0]           asm_keep;
   logic [RATIO-1:0]           merged_keep;
   logic                       asm_last;
   logic                       ws_cap;
   logic                       out_ws;
   logic [CNT_W-1:0]           cnt;
   logic                       accept;
   logic                       out_hs;
   logic                       complete;
   logic                       group_ws;

   // Valid/ready: a transfer happens on any edge where valid and ready are
   // both high; valid never waits on ready, and input ready depends only on
   // the output register (empty, or being emptied this cycle).
   assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign out_hs        = m_axis_tvalid & m_axis_tready;
   assign complete      = accept & ((cnt == CNT_W'(RATIO - 1)) |
                                    (FLUSH_ON_LAST & s_axis_tlast));
   // A group closed by its own first beat never went through ws_cap.
   assign group_ws      = (cnt == '0) ? weight_switch : ws_cap;
   assign beat_cnt_o    = cnt;

   always_comb begin
      merged_data = asm_data;
      merged_keep = asm_keep;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt == CNT_W'(k)) begin
            merged_data[k] = s_axis_tdata;
            merged_keep[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         asm_data <= '0;
         asm_keep <= '0;
         asm_last <= 1'b0;
         cnt      <= '0;
         ws_cap   <= 1'b0;
      end else if (accept) begin
         if (complete) begin
            asm_data <= '0;
            asm_keep <= '0;
            asm_last <= 1'b0;
            cnt      <= '0;
         end else begin
            asm_data <= merged_data;
            asm_keep <= merged_keep;
            asm_last <= asm_last | s_axis_tlast;
            cnt      <= cnt + CNT_W'(1);
            if (cnt == '0) begin
               ws_cap <= weight_switch;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_ws            <= 1'b0;
         weight_switch_out <= 1'b0;
      end else begin
         if (complete) begin
            out_ws <= group_ws;
         end
         weight_switch_out <= out_hs & m_axis_tlast & out_ws;
      end
   end

   axis_out_reg #(
      .DATA_W (OUT_W),
      .KEEP_W (RATIO)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (complete),
      .drain   (out_hs),
      .in_data (merged_data),
      .in_keep (merged_keep),
      .in_last (asm_last | s_axis_tlast),
      .tdata   (m_axis_tdata),
      .tkeep   (m_axis_tkeep),
      .tlast   (m_axis_tlast),
      .tvalid  (m_axis_tvalid)
   );

endmodule

// File: tb/tb_axis_upsizer_ws.sv
// Bench for axis_upsizer_ws at IN_W=8, RATIO=4: flushing instance checked by
// a word scoreboard and hand sequences, plus a non-flushing instance.
module tb_axis_upsizer_ws;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast, ws_in;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid, m_tready, m_tlast, ws_out;
   logic [2:0]  beat_cnt;

   logic [7:0]  n_s_tdata;
   logic        n_s_tvalid, n_s_tready, n_s_tlast;
   logic [31:0] n_m_tdata;
   logic [3:0]  n_m_tkeep;
   logic        n_m_tvalid, n_m_tlast, n_ws_out;
   logic [2:0]  n_beat_cnt;

   int total = 0;
   int bad   = 0;
   int last_wait;
   int ws_pulses = 0;
   bit rand_bp = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   axis_upsizer_ws #(.IN_W(8), .RATIO(4), .FLUSH_ON_LAST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .weight_switch(ws_in),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .weight_switch_out(ws_out), .beat_cnt_o(beat_cnt)
   );

   axis_upsizer_ws #(.IN_W(8), .RATIO(4), .FLUSH_ON_LAST(1'b0)) dut_nf (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(n_s_tdata), .s_axis_tvalid(n_s_tvalid), .s_axis_tready(n_s_tready),
      .s_axis_tlast(n_s_tlast), .weight_switch(1'b0),
      .m_axis_tdata(n_m_tdata), .m_axis_tkeep(n_m_tkeep), .m_axis_tvalid(n_m_tvalid),
      .m_axis_tready(1'b1), .m_axis_tlast(n_m_tlast),
      .weight_switch_out(n_ws_out), .beat_cnt_o(n_beat_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every output handshake pops one expected {data, keep, last}.
   always @(negedge clk) begin
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got word %h, want no word", m_tdata);
         end else begin
            check("sb_word", {m_tdata, m_tkeep, m_tlast}, exp_q.pop_front());
         end
      end
      if (ws_out) ws_pulses++;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input logic w);
      logic acc;
      int n;
      s_tdata  = d;
      s_tlast  = l;
      ws_in    = w;
      s_tvalid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         if (rand_bp) m_tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = s_tready;
         cycle();
         n++;
      end
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
      last_wait = n;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      ws_in    = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_q.push_back({d, k, l});
   endtask

   typedef struct {
      int          n;
      logic [31:0] beats;
      logic        last;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
      logic        exp_last;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int p0;
      vecs[0] = '{4, 32'h44332211, 1'b1, 32'h44332211, 4'b1111, 1'b1};
      vecs[1] = '{2, 32'h0000B2A1, 1'b1, 32'h0000B2A1, 4'b0011, 1'b1};
      vecs[2] = '{4, 32'h88776655, 1'b0, 32'h88776655, 4'b1111, 1'b0};
      vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001, 1'b1};
      vecs[4] = '{3, 32'h00C3C2C1, 1'b1, 32'h00C3C2C1, 4'b0111, 1'b1};

      rst_n = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; ws_in = 1'b0; m_tready = 1'b0;
      n_s_tdata = '0; n_s_tvalid = 1'b0; n_s_tlast = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      check("rst_tdata", 64'(m_tdata), 0);
      check("rst_tkeep", 64'(m_tkeep), 0);
      check("rst_tvalid", 64'(m_tvalid), 0);
      check("rst_tlast", 64'(m_tlast), 0);
      check("rst_ws_out", 64'(ws_out), 0);
      check("rst_beat_cnt", 64'(beat_cnt), 0);
      check("rst_s_tready", 64'(s_tready), 1);

      // Back-to-back full group with no input stall.
      m_tready = 1'b1;
      push_exp(32'h44332211, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_beat(8'(8'h11 * (i + 1)), i == 3, 1'b0);
         check("t1_no_stall", 64'(last_wait), 1);
      end
      check("t1_tvalid", 64'(m_tvalid), 1);
      check("t1_tdata", 64'(m_tdata), 64'h44332211);
      check("t1_tkeep", 64'(m_tkeep), 64'hf);
      check("t1_tlast", 64'(m_tlast), 1);
      cycle();
      check("t1_tvalid_drop", 64'(m_tvalid), 0);

      // Table of groups, including early flushes.
      for (int v = 0; v < 5; v++) begin
         push_exp(vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last);
         for (int i = 0; i < vecs[v].n; i++) begin
            send_beat(vecs[v].beats[i*8 +: 8], vecs[v].last && (i == vecs[v].n - 1), 1'b0);
         end
      end
      repeat (2) cycle();

      // Backpressure hold, with the next beat waiting at the input.
      push_exp(32'h44332211, 4'b1111, 1'b1);
      push_exp(32'h88776655, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(8'(8'h11 * (i + 1)), i == 3, 1'b0);
      m_tready = 1'b0;
      s_tdata = 8'h55; s_tvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t3_hold_tvalid", 64'(m_tvalid), 1);
         check("t3_hold_tdata", {m_tdata, m_tkeep, m_tlast}, {32'h44332211, 4'hf, 1'b1});
         check("t3_hold_s_tready", 64'(s_tready), 0);
         cycle();
      end
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(8'(8'h55 + 8'h11 * i), 1'b0, 1'b0);
      repeat (2) cycle();

      // Weight switch pulse after the handshake of a tlast word.
      p0 = ws_pulses;
      push_exp(32'h04030201, 4'b1111, 1'b1);
      for (int i = 0; i < 4; i++) send_beat(8'(i + 1), i == 3, i == 0);
      check("t4_ws_before", 64'(ws_out), 0);
      cycle();
      check("t4_ws_pulse", 64'(ws_out), 1);
      cycle();
      check("t4_ws_after", 64'(ws_out), 0);
      check("t4_ws_count", 64'(ws_pulses - p0), 1);
      p0 = ws_pulses;
      push_exp(32'h04030201, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(8'(i + 1), 1'b0, i == 0);
      repeat (3) cycle();
      check("t4_no_last_no_pulse", 64'(ws_pulses - p0), 0);
      p0 = ws_pulses;
      push_exp(32'h0000005A, 4'b0001, 1'b1);
      send_beat(8'h5A, 1'b1, 1'b1);
      repeat (3) cycle();
      check("t4_single_beat_pulse", 64'(ws_pulses - p0), 1);

      // Reset in the middle of a group discards it.
      send_beat(8'hEE, 1'b0, 1'b1);
      send_beat(8'hFF, 1'b0, 1'b0);
      check("t5_cnt_before", 64'(beat_cnt), 2);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("t5_tdata", 64'(m_tdata), 0);
      check("t5_tkeep", 64'(m_tkeep), 0);
      check("t5_tvalid", 64'(m_tvalid), 0);
      check("t5_ws_out", 64'(ws_out), 0);
      check("t5_beat_cnt", 64'(beat_cnt), 0);
      push_exp(32'h04030201, 4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(8'(i + 1), 1'b0, 1'b0);
      repeat (2) cycle();

      // Non-flushing instance: tlast mid-group does not close the group.
      for (int i = 0; i < 4; i++) begin
         n_s_tdata = 8'(8'hD1 + i);
         n_s_tlast = (i == 1);
         n_s_tvalid = 1'b1;
         @(negedge clk);
         check("t6_no_early_word", 64'(n_m_tvalid), 0);
         check("t6_s_tready", 64'(n_s_tready), 1);
         cycle();
      end
      n_s_tvalid = 1'b0;
      n_s_tlast = 1'b0;
      check("t6_tvalid", 64'(n_m_tvalid), 1);
      check("t6_word", {n_m_tdata, n_m_tkeep, n_m_tlast}, {32'hD4D3D2D1, 4'hf, 1'b1});

      // Random groups under random output backpressure.
      rand_bp = 1;
      for (int g = 0; g < 12; g++) begin
         logic [31:0] ed;
         logic [3:0]  ek;
         logic [7:0]  b;
         int n;
         logic lf;
         n  = $urandom_range(1, 4);
         lf = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
         ed = '0;
         ek = '0;
         for (int i = 0; i < n; i++) ed[i*8 +: 8] = 8'($urandom_range(0, 255));
         for (int i = 0; i < n; i++) ek[i] = 1'b1;
         push_exp(ed, ek, lf);
         for (int i = 0; i < n; i++) begin
            b = ed[i*8 +: 8];
            send_beat(b, lf && (i == n - 1), 1'b0);
         end
      end
      rand_bp = 0;
      m_tready = 1'b1;
      repeat (5) cycle();
      check("sb_queue_empty", 64'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_upsizer_ws.md
Name: axis_upsizer_ws

Overview:
Parametrised AXI-Stream width upsizer for the data-route fabric. It packs RATIO input beats of IN_W bits into one output word of IN_W*RATIO bits, LSB-first. Unlike the fixed 1536->6144 packer, it adds:
- early flush on tlast, with zero padding and a beat-keep mask;
- sustained one-beat-per-cycle throughput;
- a one-cycle weight-switch pulse.
It sits between the DMA read stream and the systolic-array weight/feature loaders.

Parameters:
IN_W, 1536, input beat width in bits (>=8)
RATIO, 4, input beats per output word (2..16)
FLUSH_ON_LAST, 1, 1 = a tlast beat closes the group early; 0 = groups are always RATIO beats
OUT_W, IN_W*RATIO, derived output width; not overridable

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
s_axis_tdata  in  IN_W  input beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input last
weight_switch  in  1  sideband, sampled with each accepted beat
m_axis_tdata  out  OUT_W  packed word; beat k occupies [(k+1)*IN_W-1 : k*IN_W]
m_axis_tkeep  out  RATIO  bit k = slice k holds a real beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  OR of the tlast flags of the group's beats
weight_switch_out  out  1  one-cycle pulse
beat_cnt_o  out  $clog2(RATIO)+1  current assembly fill level (debug)

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - Outputs return to 0: m_axis_tdata, tkeep, tvalid, tlast, weight_switch_out and beat_cnt_o.
  - The assembly buffer, fill count and captured switch flag clear.
  - Reset mid-group discards the partial group; no output is produced for it.
- Datapath registers:
  - Assembly buffer asm_data/asm_keep/asm_last, fill count cnt in 0..RATIO-1, captured switch flag ws_cap.
  - Output register drives the m_axis_* ports.
- Handshakes:
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready. This is combinational and independent of s_axis_tvalid.
  - Sustained 1 beat/cycle in and 1 word per RATIO cycles out while m_axis_tready=1.
  - Accept = s_axis_tvalid & s_axis_tready. Output handshake = m_axis_tvalid & m_axis_tready.
- On accept of a non-completing beat:
  - Write slice cnt; set asm_keep[cnt]; OR tlast into asm_last; cnt+1.
  - If cnt==0, ws_cap <= weight_switch.
- Completing beat: cnt==RATIO-1, or (FLUSH_ON_LAST & s_axis_tlast).
  - In the same edge, load the output register with the assembled group plus this beat.
  - Unfilled slices are zero; tkeep covers only filled slices.
  - m_axis_tvalid <= 1; cnt <= 0; asm_keep, asm_last and data clear.
- Latency: m_axis_tvalid rises on the edge following acceptance of the completing beat.
- Output hold:
  - While m_axis_tvalid & ~m_axis_tready, all m_axis_* are stable.
  - No input is accepted while the output is held, because s_axis_tready=0.
- Simultaneous events: an output handshake and a completing accept in the same cycle reload the output register and keep valid=1, with no bubble.
- Drain: an output handshake with no completing accept clears m_axis_tvalid on the next edge. tdata is left unchanged; only valid drops.
- weight_switch_out: asserted one cycle, on the edge after an output handshake whose word has m_axis_tlast=1 and whose group had ws_cap=1. Low otherwise.
- FLUSH_ON_LAST=0: tlast mid-group is only ORed into asm_last. The group still waits for RATIO beats.
- A tlast on the beat at cnt==0 with flush enabled yields a word with tkeep=...0001.
- No state machine beyond cnt plus the output-valid flag. The two states, EMPTY and FULL, are encoded by m_axis_tvalid.

Decomposition:
- Shared package psys_route_pkg:
  - localparam helpers: clog2 function, default widths PSYS_BEAT_W=1536 and PSYS_WORD_W=6144;
  - typedef for the keep mask width.
- Sub-module axis_out_reg: single-entry output register holding tdata/tkeep/tlast/tvalid with load/drain control. It is reusable by the matching downsizer.
- Packing logic stays in the top module.

Test Plan:
Bench config IN_W=8, RATIO=4.
1. Back-to-back full group: beats 0x11,0x22,0x33,0x44 with tlast on 0x44 and m_ready=1. Required: one cycle after the 4th accept, tdata=0x44332211, tkeep=4'b1111, tlast=1, tvalid for 1 cycle; s_axis_tready never drops.
2. Early flush: beats 0xA1,0xB2 with tlast on 0xB2 and FLUSH_ON_LAST=1. Required: tdata=0x0000B2A1, tkeep=4'b0011, tlast=1.
3. Backpressure: m_ready=0 for 5 cycles after word 0x44332211. Required: output stable for all 5 cycles and s_axis_tready=0. On release, next group 0x88776655 follows with no lost beats.
4. Weight switch: first beat of a tlast group has weight_switch=1 and m_ready=1. Required: weight_switch_out=1 exactly on the edge after the handshake. The same stimulus without tlast gives no pulse.
5. Reset mid-group: 2 beats accepted, then rst_n=0 for 1 cycle. Required: all outputs 0 and beat_cnt_o=0. The next 4 beats 0x01..0x04 produce 0x04030201 only.
6. FLUSH_ON_LAST=0: tlast on beat 2 of 4. Required: word emitted only after 4 beats, tkeep=4'b1111, tlast=1.
